mw_add5_seq: RTL

//  Multi-word add/subtract sequencer sitting directly upstream of the 5-bit ripple adder (add5 core).

---
 rtl/mw_add5_seq_if.sv | 26 ++
 rtl/mw_add5_seq.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mw_add5_seq_if.sv
// Operand-in / sum-out stream bundle between the producer/consumer and the mw_add5_seq sequencer.
// Both streams use valid/ready: a word moves on a rising edge where valid and ready are both high; valid never waits on ready.
interface mw_add5_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_a;
  logic [4:0] in_b;
  logic       in_first;
  logic       in_last;
  logic       in_sub;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_y;
  logic       out_last;
  logic       out_cout;

  modport master (
    output in_valid, in_a, in_b, in_first, in_last, in_sub, out_ready,
    input  in_ready, out_valid, out_y, out_last, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_first, in_last, in_sub, out_ready,
    output in_ready, out_valid, out_y, out_last, out_cout
  );
endinterface

// File: rtl/mw_add5_seq.sv
// Multi-word add/subtract sequencer driving an external 5-bit ripple adder; chains carries word to word, LSW first.
// 5-bit buses use the adder's bit order: [4] is the LSB, [0] is the MSB.
module mw_add5_seq #(
  parameter int MAX_WORDS = 8,
  parameter int CNT_W     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mw_add5_seq_if.slave    bus,
  output logic [4:0]      add_a,
  output logic [4:0]      add_b,
  output logic            add_cin,
  input  logic [4:0]      add_y,
  input  logic            add_cout,
  output logic            err_proto,
  output logic            err_len,
  output logic            dbg_state_o,
  output logic [CNT_W-1:0] dbg_cnt_o,
  output logic            dbg_carry_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [4:0]       out_y_q, out_y_d;
  logic             out_last_q, out_last_d;
  logic             out_cout_q, out_cout_d;
  logic             err_proto_q, err_proto_d;
  logic             err_len_q, err_len_d;

  logic accept;
  logic start;
  logic sub_eff;

  // A word arriving while idle starts a chain even without in_first.
  assign start   = (state_q == IDLE) | bus.in_first;
  assign sub_eff = start ? bus.in_sub : sub_q;

  assign bus.in_ready = !out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  assign add_a   = bus.in_a;
  assign add_b   = sub_eff ? ~bus.in_b : bus.in_b;
  assign add_cin = start ? bus.in_sub : carry_q;

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    err_proto_d = 1'b0;
    err_len_d   = 1'b0;

    if (accept) begin
      out_y_d     = add_y;
      out_last_d  = bus.in_last;
      out_cout_d  = add_cout;
      out_valid_d = 1'b1;
      carry_d     = add_cout;

      if (start) begin
        sub_d = bus.in_sub;
        cnt_d = CNT_ONE;
      end else if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + CNT_ONE;
      end

      err_proto_d = (state_q == IDLE) ? !bus.in_first : bus.in_first;
      err_len_d   = (state_q == RUN) && (cnt_q == CNT_MAX) && !bus.in_last;

      // Closing word of any chain, even a one-word chain, returns to IDLE.
      if (bus.in_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = RUN;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= 5'd0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      err_proto_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      err_proto_q <= err_proto_d;
      err_len_q   <= err_len_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_cout  = out_cout_q;
  assign err_proto     = err_proto_q;
  assign err_len       = err_len_q;

  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;
  assign dbg_carry_o = carry_q;

endmodule
